ram_fifo_ctrl: RTL and testbench
================================

Name: ram_fifo_ctrl

Overview:
Synchronous FIFO controller that sequences the library dual-port RAM (one asynchronous read port, one synchronous write port) as a circular buffer. It owns the head and tail pointers, the occupancy count, full/empty status and the valid/ready handshakes on both sides. It is used wherever a pipeline stage needs elastic buffering between producer and consumer, for example ahead of the dispatch and writeback queues.

Parameters:
OPTN_DATA_WIDTH, 8, entry width in bits.
OPTN_FIFO_DEPTH, 8, number of entries; must be a power of 2 and >= 2.
OPTN_AF_THRESHOLD, OPTN_FIFO_DEPTH-2, occupancy at which almost-full asserts. Used only with RAM_FIFO_CTRL_ALMOST_FULL_EN.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
i_flush  input  1  synchronous clear of all entries
i_enq_valid  input  1  producer has data
o_enq_ready  output  1  FIFO can accept data
i_enq_data  input  OPTN_DATA_WIDTH  enqueue data
o_deq_valid  output  1  head entry valid
i_deq_ready  input  1  consumer accepts head
o_deq_data  output  OPTN_DATA_WIDTH  head entry data
o_count  output  $clog2(OPTN_FIFO_DEPTH)+1  current occupancy
o_almost_full  output  1  present only with RAM_FIFO_CTRL_ALMOST_FULL_EN

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values, sampled at the clk edge with rst=1: head=0, tail=0, o_count=0, o_enq_ready=1, o_deq_valid=0, o_deq_data=0, o_almost_full=0.
- Pointers: head and tail are $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - empty = (head == tail).
  - full = index bits equal and wrap bits differ.
  - Index wrap from DEPTH-1 to 0 toggles the wrap bit.
- Enqueue fires when i_enq_valid && o_enq_ready:
  - RAM write enable is asserted, with the write address taken from the tail index.
  - tail increments at the clk edge.
- Dequeue fires when o_deq_valid && i_deq_ready; head increments at the clk edge.
- Handshake outputs: o_enq_ready = !full and o_deq_valid = !empty, both combinational from registered pointers. There is no combinational path from i_enq_valid or i_deq_ready to either ready or valid.
- RAM read side: the read enable is !empty and the read address is the head index.
  - o_deq_data comes from the asynchronous RAM read. It is 0 when the FIFO is empty, because the read is gated.
  - The RAM reset input is driven with !rst.
- Latency: data enqueued in cycle N is visible with o_deq_valid=1 in cycle N+1. There is no same-cycle fall-through.
- Simultaneous enqueue and dequeue:
  - When neither full nor empty, both fire and o_count is unchanged.
  - When full, enqueue is blocked (o_enq_ready=0) and only the dequeue fires.
  - When empty, only the enqueue fires.
- o_count: registered; +1 on enqueue only, -1 on dequeue only, otherwise held. It never exceeds DEPTH and never underflows.
- Flush: i_flush=1 sets head=tail=0 and count=0 at the next edge.
  - Flush takes priority over any enqueue or dequeue in the same cycle. A handshake that appears to complete in that cycle is dropped, and no pointer or count update occurs.
  - RAM contents are not cleared.
- Reset mid-operation: identical to flush. All buffered data is discarded, and outputs return to reset values in the next cycle.
- No error outputs. Enqueue when full and dequeue when empty are simply not handshaken.

Optional Feature:
RAM_FIFO_CTRL_ALMOST_FULL_EN
- With the macro defined, a registered o_almost_full is present and parameter OPTN_AF_THRESHOLD is used.
  - o_almost_full is set at the edge where the next count >= OPTN_AF_THRESHOLD.
  - It is cleared at the edge where the next count < OPTN_AF_THRESHOLD.
  - It tracks o_count in the same cycle: no extra lag.
  - Reset and flush clear it.
- Without the macro, the o_almost_full port and its logic are absent.

Decomposition:
- Shared package: no typedefs needed.
- Derived localparams stay local: FIFO_IDX_WIDTH = $clog2(OPTN_FIFO_DEPTH) and FIFO_CNT_WIDTH = FIFO_IDX_WIDTH+1.
- Sub-module: ram_fifo_ptr, a wrap-bit pointer counter with increment and clear inputs, instantiated twice (head and tail).
- The RAM primitive is instantiated unmodified.

Test Plan:
1. Reset then idle: o_enq_ready=1, o_deq_valid=0, o_count=0, o_deq_data=0.
2. DEPTH=8. Enqueue 0x01..0x08 back-to-back, no dequeue → o_enq_ready=0 after the 8th enqueue and o_count=8. A 9th enqueue of 0xAA is not accepted. Then dequeue all 8 → 0x01..0x08 come out in order, after which o_deq_valid=0.
3. Single enqueue of 0x5A in cycle N → o_deq_valid=1 and o_deq_data=0x5A in cycle N+1, not in cycle N.
4. Stream 20 entries with enqueue and dequeue both asserted every cycle after the first → o_count holds at 1, data is in order, and the pointers wrap twice without loss.
5. At o_count=5, assert i_flush together with i_enq_valid and i_deq_ready → next cycle o_count=0 and o_deq_valid=0. The flushed enqueue's data is not dequeued later.
6. With RAM_FIFO_CTRL_ALMOST_FULL_EN, threshold 6: enqueue 6 → o_almost_full=1 in the same cycle o_count=6. Dequeue 1 → o_almost_full=0 when o_count=5. Reset asserted at o_count=7 → all outputs return to reset values.

Source files
------------

// File: rtl/ram_fifo_ctrl_pkg.sv
// ram_fifo_ctrl_pkg: shared defaults for the RAM-backed FIFO controller
// Holds the default data width and depth used by the controller and its RAM.
package ram_fifo_ctrl_pkg;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_FIFO_DEPTH = 8;
endpackage

// File: rtl/ram_dp_ar_sw.sv
// ram_dp_ar_sw: library dual-port RAM, synchronous write port, asynchronous read port
// Ports: clk, rst_n (read gate), i_we/i_waddr/i_wdata (write), i_re/i_raddr/o_rdata (read).
// Read data is forced to 0 while the read is disabled or the RAM is held in reset.
module ram_dp_ar_sw
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int OPTN_DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int OPTN_DEPTH      = DEF_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_we,
    input  logic [$clog2(OPTN_DEPTH)-1:0] i_waddr,
    input  logic [OPTN_DATA_WIDTH-1:0]    i_wdata,
    input  logic                          i_re,
    input  logic [$clog2(OPTN_DEPTH)-1:0] i_raddr,
    output logic [OPTN_DATA_WIDTH-1:0]    o_rdata
);
    logic [OPTN_DATA_WIDTH-1:0] mem [OPTN_DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) mem[i_waddr] <= i_wdata;
    end

    always_comb o_rdata = (i_re && rst_n) ? mem[i_raddr] : '0;
endmodule

// File: rtl/ram_fifo_ptr.sv
// ram_fifo_ptr: wrap-bit circular-buffer pointer with increment and clear
// Ports: clk, rst (sync, active-high), i_clr (sync clear), i_inc (advance), o_ptr (index plus wrap MSB).
// Depth is a power of two, so a plain binary increment toggles the wrap bit on index rollover.
module ram_fifo_ptr #(
    parameter int IDX_W = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_clr,
    input  logic           i_inc,
    output logic [IDX_W:0] o_ptr
);
    logic [IDX_W:0] ptr_q, ptr_d;

    always_comb ptr_d = i_clr ? '0 : ptr_q + (IDX_W+1)'(i_inc);

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

    assign o_ptr = ptr_q;
endmodule

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller sequencing a dual-port RAM as a circular buffer
// Ports: clk, rst (sync, active-high), i_flush, i_enq_valid/o_enq_ready/i_enq_data,
//        o_deq_valid/i_deq_ready/o_deq_data, o_count, o_almost_full (optional).
// Optional macro RAM_FIFO_CTRL_ALMOST_FULL_EN adds a registered o_almost_full at OPTN_AF_THRESHOLD.
module ram_fifo_ctrl
    import ram_fifo_ctrl_pkg::*;
#(
    parameter int OPTN_DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int OPTN_FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int OPTN_AF_THRESHOLD = OPTN_FIFO_DEPTH - 2
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_flush,
    input  logic                               i_enq_valid,
    output logic                               o_enq_ready,
    input  logic [OPTN_DATA_WIDTH-1:0]         i_enq_data,
    output logic                               o_deq_valid,
    input  logic                               i_deq_ready,
    output logic [OPTN_DATA_WIDTH-1:0]         o_deq_data,
`ifdef RAM_FIFO_CTRL_ALMOST_FULL_EN
    output logic                               o_almost_full,
`endif
    output logic [$clog2(OPTN_FIFO_DEPTH):0]   o_count
);
    localparam int FIFO_IDX_WIDTH = $clog2(OPTN_FIFO_DEPTH);
    localparam int FIFO_CNT_WIDTH = FIFO_IDX_WIDTH + 1;

    logic [FIFO_CNT_WIDTH-1:0] head, tail, count_q, count_d;
    logic full, empty, enq_fire, deq_fire;

    ram_fifo_ptr #(.IDX_W(FIFO_IDX_WIDTH)) u_head (
        .clk(clk), .rst(rst), .i_clr(i_flush), .i_inc(deq_fire), .o_ptr(head)
    );

    ram_fifo_ptr #(.IDX_W(FIFO_IDX_WIDTH)) u_tail (
        .clk(clk), .rst(rst), .i_clr(i_flush), .i_inc(enq_fire), .o_ptr(tail)
    );

    // Flush drops any handshake in its cycle, so neither fire nor RAM write happens.
    always_comb begin
        empty    = head == tail;
        full     = (head[FIFO_IDX_WIDTH-1:0] == tail[FIFO_IDX_WIDTH-1:0]) &&
                   (head[FIFO_IDX_WIDTH] != tail[FIFO_IDX_WIDTH]);
        enq_fire = i_enq_valid && !full && !i_flush;
        deq_fire = i_deq_ready && !empty && !i_flush;
        count_d  = i_flush ? '0 : count_q + FIFO_CNT_WIDTH'(enq_fire) - FIFO_CNT_WIDTH'(deq_fire);
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    ram_dp_ar_sw #(.OPTN_DATA_WIDTH(OPTN_DATA_WIDTH), .OPTN_DEPTH(OPTN_FIFO_DEPTH)) u_ram (
        .clk    (clk),
        .rst_n  (!rst),
        .i_we   (enq_fire),
        .i_waddr(tail[FIFO_IDX_WIDTH-1:0]),
        .i_wdata(i_enq_data),
        .i_re   (!empty),
        .i_raddr(head[FIFO_IDX_WIDTH-1:0]),
        .o_rdata(o_deq_data)
    );

    assign o_enq_ready = !full;
    assign o_deq_valid = !empty;
    assign o_count     = count_q;

`ifdef RAM_FIFO_CTRL_ALMOST_FULL_EN
    localparam logic [FIFO_CNT_WIDTH-1:0] AF_THR = FIFO_CNT_WIDTH'(OPTN_AF_THRESHOLD);
    logic af_q, af_d;

    // Derived from the next count so the flag lands on the same edge as o_count.
    always_comb af_d = count_d >= AF_THR;

    always_ff @(posedge clk) begin
        if (rst) af_q <= 1'b0;
        else     af_q <= af_d;
    end

    assign o_almost_full = af_q;
`endif
endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// tb_ram_fifo_ctrl: self-checking bench for ram_fifo_ctrl against a queue model
module tb_ram_fifo_ctrl;
    localparam int DW = 8;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_flush = 1'b0;
    logic i_enq_valid = 1'b0;
    logic [DW-1:0] i_enq_data = '0;
    logic i_deq_ready = 1'b0;
    logic o_enq_ready, o_deq_valid;
    logic [DW-1:0] o_deq_data;
    logic [3:0] o_count;
`ifdef RAM_FIFO_CTRL_ALMOST_FULL_EN
    logic o_almost_full;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;
    logic [DW-1:0] model_q [$];

    always #5 clk = ~clk;

    ram_fifo_ctrl #(.OPTN_DATA_WIDTH(DW), .OPTN_FIFO_DEPTH(DEPTH), .OPTN_AF_THRESHOLD(6)) dut (
        .clk(clk),
        .rst(rst),
        .i_flush(i_flush),
        .i_enq_valid(i_enq_valid),
        .o_enq_ready(o_enq_ready),
        .i_enq_data(i_enq_data),
        .o_deq_valid(o_deq_valid),
        .i_deq_ready(i_deq_ready),
        .o_deq_data(o_deq_data),
`ifdef RAM_FIFO_CTRL_ALMOST_FULL_EN
        .o_almost_full(o_almost_full),
`endif
        .o_count(o_count)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Queue model: a transfer happens only if the queue has room / has data and no flush/reset.
    always @(posedge clk) begin
        if (rst || i_flush) model_q.delete();
        else begin
            bit do_enq, do_deq;
            do_enq = i_enq_valid && (model_q.size() < DEPTH);
            do_deq = i_deq_ready && (model_q.size() > 0);
            if (do_deq) void'(model_q.pop_front());
            if (do_enq) model_q.push_back(i_enq_data);
        end
        started <= 1'b1;
    end

    always @(negedge clk) begin
        if (started) begin
            chk("mdl_enq_ready", int'(o_enq_ready), int'(model_q.size() < DEPTH));
            chk("mdl_deq_valid", int'(o_deq_valid), int'(model_q.size() > 0));
            chk("mdl_count", int'(o_count), model_q.size());
            chk("mdl_deq_data", int'(o_deq_data), model_q.size() > 0 ? int'(model_q[0]) : 0);
`ifdef RAM_FIFO_CTRL_ALMOST_FULL_EN
            chk("mdl_af", int'(o_almost_full), int'(model_q.size() >= 6));
`endif
        end
    end

    task automatic drive(input logic ev, input logic [DW-1:0] d, input logic dr, input logic fl);
        #1;
        i_enq_valid = ev;
        i_enq_data  = d;
        i_deq_ready = dr;
        i_flush     = fl;
    endtask

    task automatic step(input logic ev, input logic [DW-1:0] d, input logic dr, input logic fl);
        drive(ev, d, dr, fl);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_enq_ready", int'(o_enq_ready), 1);
        chk("rst_deq_valid", int'(o_deq_valid), 0);
        chk("rst_count", int'(o_count), 0);
        chk("rst_deq_data", int'(o_deq_data), 0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_count", int'(o_count), 0);

        for (int i = 1; i <= 8; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        chk("full_ready", int'(o_enq_ready), 0);
        chk("full_count", int'(o_count), 8);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        chk("full_blocked_count", int'(o_count), 8);
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, '0, 1'b1, 1'b0);
            chk("drain_data", int'(o_deq_data), i);
            @(negedge clk);
        end
        chk("drain_empty", int'(o_deq_valid), 0);
        chk("drain_data_zero", int'(o_deq_data), 0);

        drive(1'b1, 8'h5A, 1'b0, 1'b0);
        chk("lat_cycle_n_valid", int'(o_deq_valid), 0);
        @(negedge clk);
        chk("lat_n1_valid", int'(o_deq_valid), 1);
        chk("lat_n1_data", int'(o_deq_data), 'h5A);
        step(1'b0, '0, 1'b1, 1'b0);

        step(1'b1, 8'h10, 1'b0, 1'b0);
        for (int k = 1; k < 20; k++) begin
            drive(1'b1, DW'(8'h10 + k), 1'b1, 1'b0);
            chk("stream_count", int'(o_count), 1);
            chk("stream_data", int'(o_deq_data), 'h10 + k - 1);
            @(negedge clk);
        end
        chk("stream_last", int'(o_deq_data), 'h23);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("stream_empty", int'(o_deq_valid), 0);

        for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h21 + i), 1'b0, 1'b0);
        chk("flush_pre_count", int'(o_count), 5);
        step(1'b1, 8'hEE, 1'b1, 1'b1);
        chk("flush_count", int'(o_count), 0);
        chk("flush_valid", int'(o_deq_valid), 0);
        step(1'b1, 8'h30, 1'b0, 1'b0);
        chk("post_flush_data", int'(o_deq_data), 'h30);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("post_flush_empty", int'(o_deq_valid), 0);

`ifdef RAM_FIFO_CTRL_ALMOST_FULL_EN
        for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h40 + i), 1'b0, 1'b0);
        chk("af_at5", int'(o_almost_full), 0);
        step(1'b1, 8'h45, 1'b0, 1'b0);
        chk("af_at6_count", int'(o_count), 6);
        chk("af_at6", int'(o_almost_full), 1);
        step(1'b0, '0, 1'b1, 1'b0);
        chk("af_deq_count", int'(o_count), 5);
        chk("af_deq", int'(o_almost_full), 0);
        step(1'b1, 8'h46, 1'b0, 1'b0);
        step(1'b1, 8'h47, 1'b0, 1'b0);
        chk("af_at7_count", int'(o_count), 7);
        drive(1'b0, '0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("af_rst_af", int'(o_almost_full), 0);
        chk("af_rst_count", int'(o_count), 0);
        chk("af_rst_ready", int'(o_enq_ready), 1);
        chk("af_rst_valid", int'(o_deq_valid), 0);
        chk("af_rst_data", int'(o_deq_data), 0);
        #1 rst = 1'b0;
        @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
